apb_reg_slave: RTL and testbench
================================

// Module: apb_reg_slave
// PURPOSE
//  APB3 completer (slave) for the APB master in our top. Decodes four word
//  addresses onto a small register file with per-register access rights and
//  inserts a fixed number of wait states. Flags illegal accesses on PSLVERR.
//  Sits between the APB bus and the core logic that uses regB/regC and
//  supplies the regD status word.
// PARAMETERS
//  ADDR_W       32  PADDR width
//  DATA_W       32  PWDATA/PRDATA width
//  WAIT_CYCLES  1   wait states before PREADY (0 allowed)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  psel           in   1       APB select
//  penable        in   1       APB enable (access phase)
//  pwrite         in   1       1=write, 0=read
//  paddr          in   ADDR_W  word address
//  pwdata         in   DATA_W  write data
//  prdata         out  DATA_W  read data, valid only while pready=1
//  pready         out  1       transfer complete
//  pslverr        out  1       error, valid only while pready=1
//  rega_o         out  DATA_W  regA contents (RW)
//  regb_o         out  DATA_W  regB contents (RW)
//  regc_o         out  DATA_W  regC contents (write-only)
//  regc_wr_pulse  out  1       1-cycle pulse after each committed regC write
//  regd_status_i  in   DATA_W  regD source (read-only)
// BEHAVIOUR
//  Map: 5=regA RW, 10=regB RW, 15=regC WO, 20=regD RO; all else unmapped.
//  Reset (async, rst=1): state IDLE, counter 0, regA/B/C=0, prdata=0,
//    pready=0, pslverr=0, regc_wr_pulse=0. Mid-transfer reset aborts the
//    transfer with no register update.
//  FSM IDLE -> ACCESS -> IDLE:
//   IDLE: psel&!penable (setup, cycle T0) -> latch paddr/pwrite/pwdata,
//     counter<=WAIT_CYCLES, go ACCESS.
//   ACCESS: pready = (counter==0) & psel & penable; counter decrements per
//     cycle while >0. PREADY is therefore high in cycle T1+WAIT_CYCLES, for
//     exactly one cycle. The rising edge ending that cycle commits the write
//     and returns to IDLE.
//   psel dropping in ACCESS (protocol violation) -> IDLE, no write, no error.
//  Back-to-back: a setup in the cycle after PREADY is accepted (no idle gap).
//  Read: prdata = decoded register during the PREADY cycle, else 0.
//  Errors (pslverr=1 with pready, prdata=0, no state change):
//    read of regC, write of regD, any access to an unmapped address.
//  Legal write to C: regc_o updates and regc_wr_pulse=1 for the next cycle.
//  Counter width = max(1, $clog2(WAIT_CYCLES+1)); no wrap (saturates at 0).
//  Full-width writes only; no PSTRB/PPROT.
// STRUCTURE
//  apb_pkg: register address constants (ADDR_REGA..REGD), access-right
//    table, FSM state enum {IDLE, ACCESS}.
//  Sub-module apb_regfile: decode, storage, RW/WO/RO checks, err/rdata out.
//  Top level holds the FSM, wait counter and APB output logic.
// TESTING (WAIT_CYCLES=1 unless stated)
//  1 write 99 @5, then read @5 -> pready in T2, pslverr=0, prdata=99, rega_o=99
//  2 write 52 @10, read @10 -> prdata=52; rega_o still 99
//  3 writes 54,53,52 @15 back-to-back -> 3 regc_wr_pulse, regc_o=52; read @15
//    -> pslverr=1, prdata=0
//  4 regd_status_i=32'hA5; read @20 x3 -> prdata=32'hA5, pslverr=0 each; write
//    45 @20 -> pslverr=1, no outputs change
//  5 access @7 -> pslverr=1; rst pulse in the wait cycle of write 77 @5 ->
//    pready never asserts, rega_o=0
//  6 WAIT_CYCLES=0 build: write/read @10 -> pready in T1, same data results

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - register map, access rights and FSM states for apb_reg_slave
package apb_pkg;

  localparam int ADDR_REGA = 5;
  localparam int ADDR_REGB = 10;
  localparam int ADDR_REGC = 15;
  localparam int ADDR_REGD = 20;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_RW,
    ACC_WO,
    ACC_RO
  } access_e;

  typedef enum logic [2:0] {
    SEL_A,
    SEL_B,
    SEL_C,
    SEL_D,
    SEL_NONE
  } reg_sel_e;

  function automatic access_e reg_access(input reg_sel_e sel);
    case (sel)
      SEL_A:   return ACC_RW;
      SEL_B:   return ACC_RW;
      SEL_C:   return ACC_WO;
      SEL_D:   return ACC_RO;
      default: return ACC_NONE;
    endcase
  endfunction

  function automatic logic access_err(input access_e acc, input logic is_write);
    return (acc == ACC_NONE) ||
           (is_write && (acc == ACC_RO)) ||
           (!is_write && (acc == ACC_WO));
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - address decode, register storage and access-right checks
module apb_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              commit_i,
  input  logic [DATA_W-1:0] regd_status_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rega_o,
  output logic [DATA_W-1:0] regb_o,
  output logic [DATA_W-1:0] regc_o,
  output logic              regc_wr_pulse_o
);

  reg_sel_e          sel;
  logic              wr_en;
  logic [DATA_W-1:0] rega_q, rega_d;
  logic [DATA_W-1:0] regb_q, regb_d;
  logic [DATA_W-1:0] regc_q, regc_d;
  logic              pulse_q, pulse_d;

  always_comb begin
    sel = SEL_NONE;
    if (addr_i == ADDR_W'(ADDR_REGA))      sel = SEL_A;
    else if (addr_i == ADDR_W'(ADDR_REGB)) sel = SEL_B;
    else if (addr_i == ADDR_W'(ADDR_REGC)) sel = SEL_C;
    else if (addr_i == ADDR_W'(ADDR_REGD)) sel = SEL_D;
  end

  assign err_o = access_err(reg_access(sel), write_i);
  assign wr_en = commit_i && write_i && !err_o;

  always_comb begin
    rdata_o = '0;
    case (sel)
      SEL_A:   rdata_o = rega_q;
      SEL_B:   rdata_o = regb_q;
      SEL_D:   rdata_o = regd_status_i;
      default: rdata_o = '0;
    endcase
  end

  // The pulse self-clears, so it is high only in the cycle after a regC commit.
  always_comb begin
    rega_d  = rega_q;
    regb_d  = regb_q;
    regc_d  = regc_q;
    pulse_d = 1'b0;
    if (wr_en) begin
      case (sel)
        SEL_A: rega_d = wdata_i;
        SEL_B: regb_d = wdata_i;
        SEL_C: begin
          regc_d  = wdata_i;
          pulse_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rega_q  <= '0;
      regb_q  <= '0;
      regc_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      regc_q  <= regc_d;
      pulse_q <= pulse_d;
    end
  end

  assign rega_o          = rega_q;
  assign regb_o          = regb_q;
  assign regc_o          = regc_q;
  assign regc_wr_pulse_o = pulse_q;

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB3 completer: transfer FSM, wait-state counter, bus outputs
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] rega_o,
  output logic [DATA_W-1:0] regb_o,
  output logic [DATA_W-1:0] regc_o,
  output logic              regc_wr_pulse,
  input  logic [DATA_W-1:0] regd_status_i
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A master dropping psel mid-transfer abandons it silently.
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (penable) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  apb_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk             (clk),
    .rst             (rst),
    .addr_i          (addr_q),
    .write_i         (write_q),
    .wdata_i         (wdata_q),
    .commit_i        (done),
    .regd_status_i   (regd_status_i),
    .rdata_o         (rf_rdata),
    .err_o           (rf_err),
    .rega_o          (rega_o),
    .regb_o          (regb_o),
    .regc_o          (regc_o),
    .regc_wr_pulse_o (regc_wr_pulse)
  );

  assign pready  = done;
  assign pslverr = done && rf_err;
  assign prdata  = (done && !write_q && !rf_err) ? rf_rdata : '0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - bench for apb_reg_slave with an abstract register-map model
module tb_apb_reg_slave;

  localparam int W1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [31:0] rega, regb, regc;
  logic        pulse;
  logic [31:0] regd;

  logic        b0_psel, b0_penable, b0_pwrite;
  logic [31:0] b0_paddr, b0_pwdata, b0_prdata;
  logic        b0_pready, b0_pslverr;
  logic [31:0] b0_rega, b0_regb, b0_regc;
  logic        b0_pulse;

  always #5 clk = ~clk;

  apb_reg_slave #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W1)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .rega_o(rega), .regb_o(regb), .regc_o(regc),
    .regc_wr_pulse(pulse), .regd_status_i(regd)
  );

  apb_reg_slave #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .psel(b0_psel), .penable(b0_penable), .pwrite(b0_pwrite),
    .paddr(b0_paddr), .pwdata(b0_pwdata), .prdata(b0_prdata), .pready(b0_pready),
    .pslverr(b0_pslverr), .rega_o(b0_rega), .regb_o(b0_regb), .regc_o(b0_regc),
    .regc_wr_pulse(b0_pulse), .regd_status_i(regd)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_rega, m_regb, m_regc;
  logic        exp_pready, exp_pslverr, exp_pulse;
  logic [31:0] exp_prdata;
  logic        pend_valid;
  logic [31:0] pend_addr, pend_data;
  logic        chk_en = 1'b0;
  int          pulse_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rega = 0; m_regb = 0; m_regc = 0;
    exp_pready = 0; exp_pslverr = 0; exp_prdata = 0; exp_pulse = 0;
    pend_valid = 0;
  endtask

  // Response of the register map for one transfer, from the access rules alone.
  task automatic model_resp(input logic w, input logic [31:0] a,
                            output logic err, output logic [31:0] rd);
    err = !(a inside {32'd5, 32'd10, 32'd15, 32'd20}) ||
          (w && a == 32'd20) || (!w && a == 32'd15);
    rd  = 0;
    if (!err && !w) rd = (a == 32'd5) ? m_rega : (a == 32'd10) ? m_regb : regd;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("pready",  {31'b0, pready},  {31'b0, exp_pready});
      chk("pslverr", {31'b0, pslverr}, {31'b0, exp_pslverr});
      chk("prdata",  prdata, exp_prdata);
      chk("rega_o",  rega, m_rega);
      chk("regb_o",  regb, m_regb);
      chk("regc_o",  regc, m_regc);
      chk("regc_wr_pulse", {31'b0, pulse}, {31'b0, exp_pulse});
      if (pulse) pulse_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_pulse = 0;
    if (pend_valid) begin
      case (pend_addr)
        32'd5:  m_rega = pend_data;
        32'd10: m_regb = pend_data;
        32'd15: begin m_regc = pend_data; exp_pulse = 1; end
        default: ;
      endcase
      pend_valid = 0;
    end
    psel = 0; penable = 0;
    exp_pready = 0; exp_pslverr = 0; exp_prdata = 0;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    logic        e;
    logic [31:0] r;
    tick();
    psel = 1; pwrite = w; paddr = a; pwdata = d;
    tick();
    model_resp(w, a, e, r);
    psel = 1; penable = 1;
    repeat (W1) begin tick(); psel = 1; penable = 1; end
    exp_pready = 1; exp_pslverr = e; exp_prdata = r;
    if (w && !e) begin pend_valid = 1; pend_addr = a; pend_data = d; end
    @(negedge clk);
    rd = prdata; er = pslverr;
  endtask

  task automatic xfer0(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic rdy, output logic [31:0] rd);
    @(posedge clk); #1;
    b0_psel = 1; b0_penable = 0; b0_pwrite = w; b0_paddr = a; b0_pwdata = d;
    @(posedge clk); #1;
    b0_penable = 1;
    @(negedge clk);
    rdy = b0_pready; rd = b0_prdata;
    @(posedge clk); #1;
    b0_psel = 0; b0_penable = 0;
  endtask

  logic [31:0] rd;
  logic        er, rdy;

  initial begin
    rst = 1;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    b0_psel = 0; b0_penable = 0; b0_pwrite = 0; b0_paddr = 0; b0_pwdata = 0;
    regd = 32'hA5;
    model_reset();
    @(negedge clk);
    chk("rst_pready", {31'b0, pready}, 32'd0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_rega", rega, 32'd0);
    chk("rst_regb", regb, 32'd0);
    chk("rst_regc", regc, 32'd0);
    chk("rst_pulse", {31'b0, pulse}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    chk_en = 1;

    xfer(1, 5, 99, rd, er);
    xfer(0, 5, 0, rd, er);
    chk("t1_rd", rd, 32'd99);
    chk("t1_err", {31'b0, er}, 32'd0);
    tick();
    chk("t1_rega", rega, 32'd99);

    tick(); psel = 1; pwrite = 1; paddr = 5; pwdata = 11;
    tick();
    tick();
    chk("drop_psel_rega", rega, 32'd99);

    xfer(1, 10, 52, rd, er);
    xfer(0, 10, 0, rd, er);
    chk("t2_rd", rd, 32'd52);
    chk("t2_rega", rega, 32'd99);

    tick();
    pulse_cnt = 0;
    xfer(1, 15, 54, rd, er);
    xfer(1, 15, 53, rd, er);
    xfer(1, 15, 52, rd, er);
    xfer(0, 15, 0, rd, er);
    chk("t3_err", {31'b0, er}, 32'd1);
    chk("t3_rd", rd, 32'd0);
    tick();
    chk("t3_pulses", pulse_cnt, 32'd3);
    chk("t3_regc", regc, 32'd52);

    for (int i = 0; i < 3; i++) begin
      xfer(0, 20, 0, rd, er);
      chk("t4_rd", rd, 32'hA5);
      chk("t4_err", {31'b0, er}, 32'd0);
    end
    xfer(1, 20, 45, rd, er);
    chk("t4_werr", {31'b0, er}, 32'd1);

    xfer(0, 7, 0, rd, er);
    chk("t5_unmapped_err", {31'b0, er}, 32'd1);
    chk("t5_unmapped_rd", rd, 32'd0);

    tick(); psel = 1; pwrite = 1; paddr = 5; pwdata = 77;
    tick(); psel = 1; penable = 1;
    #1 rst = 1;
    model_reset();
    #1 rst = 0;
    repeat (3) begin tick(); psel = 1; penable = 1; end
    tick();
    chk("t5_rst_rega", rega, 32'd0);
    chk("t5_rst_regc", regc, 32'd0);

    xfer0(1, 10, 52, rdy, rd);
    chk("t6_wr_pready_t1", {31'b0, rdy}, 32'd1);
    xfer0(0, 10, 0, rdy, rd);
    chk("t6_rd_pready_t1", {31'b0, rdy}, 32'd1);
    chk("t6_rd", rd, 32'd52);
    chk("t6_regb", b0_regb, 32'd52);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
